// File: rtl/acc_cmd_pkg.sv
// Shared accelerator command definitions: opcodes, sequencer state encoding, element size.
// Also used by the accelerator side so both ends agree on opcode values.
package acc_cmd_pkg;

    localparam int DCP_PADDR             = 40;
    localparam int DCP_NOC_RES_DATA_SIZE = 512;
    localparam int WORD_BYTES            = 8;

    localparam logic [5:0] OP_INIT  = 6'd10;
    localparam logic [5:0] OP_FILLA = 6'd11;
    localparam logic [5:0] OP_FILLB = 6'd12;
    localparam logic [5:0] OP_READ  = 6'd13;
    localparam logic [5:0] OP_MULT  = 6'd25;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_REQ,
        ST_WAIT,
        ST_PUSH,
        ST_MULT,
        ST_DONE
    } seq_state_t;

    function automatic logic [DCP_PADDR-1:0] align_word(input logic [DCP_PADDR-1:0] a);
        return {a[DCP_PADDR-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/acc_cmd_sequencer.sv
// Loads matrices A then B from memory into the accelerator (INIT, FILLA/FILLB per element, MULT).
// Latency: 3 cycles per element with zero-wait memory/accelerator; one memory request outstanding.
// Backpressure: holds command while acc_busy, holds request while !mem_req_rdy; ACC_SEQ_CYCLE_CNT_EN enables cycle_count.
module acc_cmd_sequencer #(
    parameter int MAT_DIM    = 10,
    parameter int WORD_BYTES = acc_cmd_pkg::WORD_BYTES
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic [acc_cmd_pkg::DCP_PADDR-1:0]           a_base,
    input  logic [acc_cmd_pkg::DCP_PADDR-1:0]           b_base,
    output logic                                        idle,
    output logic                                        done,
    output logic                                        acc_cmd_val,
    input  logic                                        acc_busy,
    output logic [5:0]                                  acc_cmd_opcode,
    output logic [63:0]                                 acc_cmd_data,
    output logic                                        mem_req_val,
    input  logic                                        mem_req_rdy,
    output logic [5:0]                                  mem_req_transid,
    output logic [acc_cmd_pkg::DCP_PADDR-1:0]           mem_req_addr,
    input  logic                                        mem_resp_val,
    input  logic [5:0]                                  mem_resp_transid,
    input  logic [acc_cmd_pkg::DCP_NOC_RES_DATA_SIZE-1:0] mem_resp_data,
    output logic [31:0]                                 cycle_count
);
    import acc_cmd_pkg::*;

    localparam int NUM_ELEM = MAT_DIM * MAT_DIM;
    localparam int IDX_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam int LANES    = DCP_NOC_RES_DATA_SIZE / 64;

    seq_state_t             state;
    logic [DCP_PADDR-1:0]   a_reg;
    logic [DCP_PADDR-1:0]   b_reg;
    logic [IDX_W-1:0]       idx;
    logic                   sel_b;

    logic                   cmd_acc;
    logic                   req_acc;
    logic                   last_elem;
    logic                   nxt_sel;
    logic [IDX_W-1:0]       nxt_idx;
    logic [63:0]            resp_word;

    function automatic logic [DCP_PADDR-1:0] elem_addr(input logic [DCP_PADDR-1:0] base,
                                                       input logic [IDX_W-1:0]     i);
        return base + DCP_PADDR'(WORD_BYTES) * DCP_PADDR'(i);
    endfunction

    assign cmd_acc   = acc_cmd_val && !acc_busy;
    assign req_acc   = mem_req_val && mem_req_rdy;
    assign last_elem = (idx == IDX_W'(NUM_ELEM - 1));
    assign nxt_idx   = last_elem ? '0 : idx + 1'b1;
    assign nxt_sel   = sel_b | last_elem;

    // The held request address picks the 64-bit lane inside the response line.
    always_comb begin
        resp_word = mem_resp_data[(int'(mem_req_addr[5:3]) % LANES) * 64 +: 64];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            idle            <= 1'b1;
            done            <= 1'b0;
            acc_cmd_val     <= 1'b0;
            acc_cmd_opcode  <= '0;
            acc_cmd_data    <= '0;
            mem_req_val     <= 1'b0;
            mem_req_transid <= '0;
            mem_req_addr    <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            idx             <= '0;
            sel_b           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    a_reg          <= align_word(a_base);
                    b_reg          <= align_word(b_base);
                    idx            <= '0;
                    sel_b          <= 1'b0;
                    idle           <= 1'b0;
                    acc_cmd_val    <= 1'b1;
                    acc_cmd_opcode <= OP_INIT;
                    acc_cmd_data   <= '0;
                    state          <= ST_INIT;
                end
                ST_INIT: if (cmd_acc) begin
                    acc_cmd_val     <= 1'b0;
                    mem_req_val     <= 1'b1;
                    mem_req_addr    <= elem_addr(a_reg, idx);
                    mem_req_transid <= 6'(idx);
                    state           <= ST_REQ;
                end
                ST_REQ: if (req_acc) begin
                    mem_req_val <= 1'b0;
                    state       <= ST_WAIT;
                end
                ST_WAIT: if (mem_resp_val && mem_resp_transid == mem_req_transid) begin
                    acc_cmd_val    <= 1'b1;
                    acc_cmd_opcode <= sel_b ? OP_FILLB : OP_FILLA;
                    acc_cmd_data   <= resp_word;
                    state          <= ST_PUSH;
                end
                ST_PUSH: if (cmd_acc) begin
                    if (last_elem && sel_b) begin
                        acc_cmd_opcode <= OP_MULT;
                        acc_cmd_data   <= '0;
                        state          <= ST_MULT;
                    end else begin
                        acc_cmd_val     <= 1'b0;
                        idx             <= nxt_idx;
                        sel_b           <= nxt_sel;
                        mem_req_val     <= 1'b1;
                        mem_req_addr    <= elem_addr(nxt_sel ? b_reg : a_reg, nxt_idx);
                        mem_req_transid <= 6'(nxt_idx);
                        state           <= ST_REQ;
                    end
                end
                ST_MULT: if (cmd_acc) begin
                    acc_cmd_val <= 1'b0;
                    done        <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    idle  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    idle  <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ACC_SEQ_CYCLE_CNT_EN
    logic [31:0] cnt;

    // Cleared when a sequence starts, frozen in IDLE so software can read the last run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (start) cnt <= '0;
        end else if (cnt != 32'hFFFF_FFFF) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign cycle_count = cnt;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_acc_cmd_sequencer.sv
// Directed bench for acc_cmd_sequencer: full load, stalls, stale response, start-ignore, mid-run reset.
module tb_acc_cmd_sequencer;
    import acc_cmd_pkg::*;

    localparam int AW = DCP_PADDR;
    localparam int RW = DCP_NOC_RES_DATA_SIZE;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] a_base = '0;
    logic [AW-1:0] b_base = '0;
    logic          idle;
    logic          done;
    logic          acc_cmd_val;
    logic          acc_busy = 1'b0;
    logic [5:0]    acc_cmd_opcode;
    logic [63:0]   acc_cmd_data;
    logic          mem_req_val;
    logic          mem_req_rdy = 1'b1;
    logic [5:0]    mem_req_transid;
    logic [AW-1:0] mem_req_addr;
    logic          mem_resp_val = 1'b0;
    logic [5:0]    mem_resp_transid = '0;
    logic [RW-1:0] mem_resp_data = '0;
    logic [31:0]   cycle_count;

    acc_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_base(a_base), .b_base(b_base),
        .idle(idle), .done(done), .acc_cmd_val(acc_cmd_val), .acc_busy(acc_busy),
        .acc_cmd_opcode(acc_cmd_opcode), .acc_cmd_data(acc_cmd_data),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
        .mem_req_transid(mem_req_transid), .mem_req_addr(mem_req_addr),
        .mem_resp_val(mem_resp_val), .mem_resp_transid(mem_resp_transid),
        .mem_resp_data(mem_resp_data), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input logic [AW-1:0] a);
        return {~a[31:0], a[31:0]};
    endfunction

    function automatic logic [RW-1:0] line_of(input logic [AW-1:0] a);
        logic [RW-1:0] l;
        for (int k = 0; k < RW / 64; k++)
            l[k*64 +: 64] = (k == int'(a[5:3])) ? word_of(a) : (64'hBAD0_0000_0000_0000 | 64'(k));
        return l;
    endfunction

    // Scoreboard / memory model state
    int            n_cmd = 0, n_req = 0, n_done = 0, n_filla = 0, n_fillb = 0;
    logic [AW-1:0] exp_a = '0, exp_b = '0;
    logic          pend = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    logic [5:0]    pend_tid = '0;
    int            pend_idx = 0;
    logic          busy_arm = 1'b0, rdy_arm = 1'b0, stale_arm = 1'b0;
    int            busy_left = 0, rdy_left = 0;
    logic          prev_cmd_stall = 1'b0, prev_req_stall = 1'b0;
    logic [5:0]    prev_op = '0, prev_tid = '0;
    logic [63:0]   prev_data = '0;
    logic [AW-1:0] prev_addr = '0;

    always @(negedge clk) begin
        logic [5:0]    eop;
        logic [63:0]   edat;
        logic [AW-1:0] eaddr;
        int            e;

        if (prev_cmd_stall) begin
            chk("cmd_hold_val", 64'(acc_cmd_val), 64'd1);
            chk("cmd_hold_op", 64'(acc_cmd_opcode), 64'(prev_op));
            chk("cmd_hold_data", acc_cmd_data, prev_data);
        end
        if (prev_req_stall) begin
            chk("req_hold_val", 64'(mem_req_val), 64'd1);
            chk("req_hold_addr", 64'(mem_req_addr), 64'(prev_addr));
            chk("req_hold_tid", 64'(mem_req_transid), 64'(prev_tid));
        end

        mem_resp_val = 1'b0;
        if (pend) begin
            mem_resp_val = 1'b1;
            if (stale_arm && pend_idx == 20) begin
                stale_arm        = 1'b0;
                mem_resp_transid = 6'h3F;
                mem_resp_data    = line_of(pend_addr + AW'(8));
            end else begin
                pend             = 1'b0;
                mem_resp_transid = pend_tid;
                mem_resp_data    = line_of(pend_addr);
            end
        end

        if (busy_arm && acc_cmd_val && acc_cmd_opcode == OP_FILLA && n_cmd == 37) begin
            busy_arm  = 1'b0;
            busy_left = 5;
        end
        acc_busy = (busy_left != 0);
        if (busy_left != 0) busy_left--;

        if (rdy_arm && mem_req_val && n_req == 10) begin
            rdy_arm  = 1'b0;
            rdy_left = 4;
        end
        mem_req_rdy = (rdy_left == 0);
        if (rdy_left != 0) rdy_left--;

        if (acc_cmd_val && !acc_busy) begin
            if (n_cmd == 0) begin
                eop = OP_INIT;  edat = '0;
            end else if (n_cmd <= 100) begin
                eop = OP_FILLA; edat = word_of(exp_a + AW'(8 * (n_cmd - 1)));
            end else if (n_cmd <= 200) begin
                eop = OP_FILLB; edat = word_of(exp_b + AW'(8 * (n_cmd - 101)));
            end else if (n_cmd == 201) begin
                eop = OP_MULT;  edat = '0;
            end else begin
                eop = '0;       edat = '0;
            end
            chk("cmd_op", 64'(acc_cmd_opcode), 64'(eop));
            chk("cmd_data", acc_cmd_data, edat);
            if (acc_cmd_opcode == OP_FILLA) n_filla++;
            if (acc_cmd_opcode == OP_FILLB) n_fillb++;
            n_cmd++;
        end

        if (mem_req_val && mem_req_rdy) begin
            e     = n_req % 100;
            eaddr = ((n_req < 100) ? exp_a : exp_b) + AW'(8 * e);
            chk("req_addr", 64'(mem_req_addr), 64'(eaddr));
            chk("req_tid", 64'(mem_req_transid), 64'(e[5:0]));
            pend      = 1'b1;
            pend_addr = mem_req_addr;
            pend_tid  = mem_req_transid;
            pend_idx  = n_req;
            n_req++;
        end

        if (done) n_done++;

        prev_cmd_stall = acc_cmd_val && acc_busy;
        prev_op        = acc_cmd_opcode;
        prev_data      = acc_cmd_data;
        prev_req_stall = mem_req_val && !mem_req_rdy;
        prev_addr      = mem_req_addr;
        prev_tid       = mem_req_transid;
    end

    task automatic launch(input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input logic [AW-1:0] ea, input logic [AW-1:0] eb);
        @(negedge clk); #2;
        n_cmd = 0; n_req = 0; n_done = 0; n_filla = 0; n_fillb = 0;
        exp_a = ea; exp_b = eb;
        a_base = a; b_base = b; start = 1'b1;
        @(negedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #2;
            if (n_done > 0) break;
        end
        chk(tag, 64'(n_done > 0), 64'd1);
        repeat (5) @(negedge clk);
        #2;
    endtask

    initial begin
        logic hit, pulsed;

        repeat (3) @(negedge clk);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_cmd_val", 64'(acc_cmd_val), 64'd0);
        chk("rst_req_val", 64'(mem_req_val), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cycle_count", 64'(cycle_count), 64'd0);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        chk("idle_no_start", 64'(idle), 64'd1);
        chk("no_start_cmd_val", 64'(acc_cmd_val), 64'd0);
        chk("no_start_req_val", 64'(mem_req_val), 64'd0);
        chk("no_start_addr", 64'(mem_req_addr), 64'd0);

        // Clean run
        launch(40'h1000, 40'h2000, 40'h1000, 40'h2000);
        chk("busy_after_start", 64'(idle), 64'd0);
        wait_done("seq1_done");
        chk("seq1_cmds", 64'(n_cmd), 64'd202);
        chk("seq1_filla", 64'(n_filla), 64'd100);
        chk("seq1_fillb", 64'(n_fillb), 64'd100);
        chk("seq1_reqs", 64'(n_req), 64'd200);
        chk("seq1_done_pulses", 64'(n_done), 64'd1);
        chk("seq1_idle", 64'(idle), 64'd1);
`ifdef ACC_SEQ_CYCLE_CNT_EN
        chk("seq1_cycle_count", 64'(cycle_count), 64'd603);
`else
        chk("seq1_cycle_count", 64'(cycle_count), 64'd0);
`endif

        // Accelerator stall on FILLA #37, network stall on request 10, stale response on request 20
        busy_arm = 1'b1; rdy_arm = 1'b1; stale_arm = 1'b1;
        launch(40'h1000, 40'h2000, 40'h1000, 40'h2000);
        wait_done("seq2_done");
        chk("seq2_cmds", 64'(n_cmd), 64'd202);
        chk("seq2_filla", 64'(n_filla), 64'd100);
        chk("seq2_reqs", 64'(n_req), 64'd200);
        chk("seq2_done_pulses", 64'(n_done), 64'd1);
        chk("seq2_stale_used", 64'(stale_arm), 64'd0);
`ifdef ACC_SEQ_CYCLE_CNT_EN
        chk("seq2_cycle_count", 64'(cycle_count), 64'd613);
        repeat (10) @(negedge clk);
        chk("seq2_count_hold", 64'(cycle_count), 64'd613);
`else
        chk("seq2_cycle_count", 64'(cycle_count), 64'd0);
`endif

        // Unaligned base, ignored start during PUSH, reset during FILLB #50
        launch(40'h1004, 40'h3000, 40'h1000, 40'h3000);
        hit = 1'b0; pulsed = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #2;
            if (start) begin
                start = 1'b0;
            end else if (!pulsed && acc_cmd_val && acc_cmd_opcode == OP_FILLA && n_cmd == 5) begin
                start = 1'b1; a_base = 40'h5000; b_base = 40'h6000; pulsed = 1'b1;
            end
            if (acc_cmd_val && acc_cmd_opcode == OP_FILLB && n_cmd == 150) begin
                rst_n = 1'b0;
                hit   = 1'b1;
                break;
            end
        end
        chk("fillb50_reached", 64'(hit), 64'd1);
        #1;
        chk("arst_idle", 64'(idle), 64'd1);
        chk("arst_cmd_val", 64'(acc_cmd_val), 64'd0);
        chk("arst_opcode", 64'(acc_cmd_opcode), 64'd0);
        chk("arst_data", acc_cmd_data, 64'd0);
        chk("arst_req_addr", 64'(mem_req_addr), 64'd0);
        chk("arst_cycle_count", 64'(cycle_count), 64'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        chk("post_rst_cmds", 64'(n_cmd), 64'd150);
        chk("post_rst_done", 64'(n_done), 64'd0);
        chk("post_rst_idle", 64'(idle), 64'd1);
        chk("post_rst_req_val", 64'(mem_req_val), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
